sqrt_seq: RTL and testbench



---
 rtl/sqrt_seq.sv | 98 +++++++++
 tb/tb_sqrt_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sqrt_seq.sv
// rtl/sqrt_seq.sv - restoring digit-by-digit square root, one root bit per clock
// root = floor(sqrt(n * 2^(2F))) in UQ(W/2).F, rem = n * 2^(2F) - root^2
module sqrt_seq #(
  parameter int W = 8,
  parameter int F = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     n,
  output logic             busy,
  output logic             done,
  output logic [W/2+F-1:0] root,
  output logic [W/2+F:0]   rem
);
  localparam int R  = W / 2 + F;
  localparam int RW = W + 2 * F;
  localparam int CW = $clog2(R + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nx;
  logic [RW-1:0] rad;
  logic [R:0]    pr;
  logic [R-1:0]  pq;
  logic [CW-1:0] cnt;

  logic [R+1:0]  t, trial, diff;
  logic          ge;
  logic [R:0]    pr_nx;
  logic [R:0]    pq_ext;
  logic [R-1:0]  pq_nx;
  logic          last;

  // One restoring step: bring down the next radicand digit pair, try subtracting 4*pq+1.
  always_comb begin
    t      = {pr[R-1:0], rad[RW-1 -: 2]};
    trial  = {pq, 2'b01};
    ge     = (t >= trial);
    diff   = t - trial;
    pr_nx  = ge ? diff[R:0] : t[R:0];
    pq_ext = {pq, ge};
    pq_nx  = pq_ext[R-1:0];
    last   = (cnt == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rad   <= '0;
      pr    <= '0;
      pq    <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      root  <= '0;
      rem   <= '0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rad <= RW'(n) << (2 * F);
            pr  <= '0;
            pq  <= '0;
            cnt <= CW'(R);
          end
        end
        RUN: begin
          rad <= rad << 2;
          pr  <= pr_nx;
          pq  <= pq_nx;
          cnt <= cnt - CW'(1);
          // Results only move on completion so they stay stable through the next run.
          if (last) begin
            root <= pq_nx;
            rem  <= pr_nx;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end
endmodule

// File: tb/tb_sqrt_seq.sv
// tb/tb_sqrt_seq.sv - directed and exhaustive self-checking bench for sqrt_seq
module tb_sqrt_seq;
  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] n;
  logic       busy, done;
  logic [7:0] root;
  logic [8:0] rem;

  logic       start6;
  logic [5:0] n6;
  logic       busy6, done6;
  logic [2:0] root6;
  logic [3:0] rem6;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sqrt_seq #(.W(8), .F(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .n(n),
    .busy(busy), .done(done), .root(root), .rem(rem)
  );

  sqrt_seq #(.W(6), .F(0)) u_dut6 (
    .clk(clk), .rst(rst), .start(start6), .n(n6),
    .busy(busy6), .done(done6), .root(root6), .rem(rem6)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Pulse start for one edge, then count edges until done (0 = timed out).
  task automatic run_op(input logic [7:0] nv, output int lat);
    @(negedge clk);
    n = nv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 8'($urandom);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic directed(input string tag, input logic [7:0] nv,
                          input logic [7:0] er, input logic [8:0] em);
    int lat;
    run_op(nv, lat);
    check({tag, "_latency"}, lat, 8);
    check({tag, "_root"}, root, er);
    check({tag, "_rem"}, rem, em);
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, done, 0);
  endtask

  initial begin
    int lat, dones, dcyc, prev, x, r;
    int dc[$];
    rst = 1'b1; start = 1'b0; n = '0; start6 = 1'b0; n6 = '0;
    repeat (3) @(posedge clk); #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_root", root, 0);
    check("reset_rem", rem, 0);
    @(negedge clk); rst = 1'b0;

    directed("n16", 8'd16, 8'h40, 9'd0);
    directed("n2", 8'd2, 8'h16, 9'd28);
    directed("n15", 8'd15, 8'h3D, 9'd119);
    directed("n0", 8'd0, 8'h00, 9'd0);
    directed("n255", 8'd255, 8'hFF, 9'd255);

    // Start n=2, retrigger with n=255 at cycle 3: must be ignored.
    @(negedge clk); n = 8'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    dones = 0; dcyc = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 3) begin start = 1'b1; n = 8'd255; end
      else start = 1'b0;
      @(posedge clk); #1;
      if (i == 2) begin
        check("hold_root_during_run", root, 8'hFF);
        check("hold_rem_during_run", rem, 9'd255);
      end
      if (done) begin dones++; dcyc = i; end
    end
    check("ignore_done_count", dones, 1);
    check("ignore_done_cycle", dcyc, 8);
    check("ignore_root", root, 8'h16);
    check("ignore_rem", rem, 9'd28);

    // Held start: back-to-back operations every 9 cycles.
    @(negedge clk); n = 8'd16; start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dc.push_back(i);
        check("held_root", root, 8'h40);
      end
    end
    @(negedge clk); start = 1'b0;
    check("held_done_count", dc.size(), 4);
    if (dc.size() > 0) check("held_first_done", dc[0], 9);
    prev = 0;
    foreach (dc[i]) begin
      if (i > 0) check("held_period", dc[i] - prev, 9);
      prev = dc[i];
    end
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!busy) begin lat = 1; break; end
    end
    check("held_drain", lat, 1);

    // Reset at cycle 4 of an operation aborts it.
    @(negedge clk); n = 8'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_root", root, 0);
    check("abort_rem", rem, 0);
    check("abort_done", done, 0);
    @(negedge clk); rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);

    // Reset and start together: reset wins.
    @(negedge clk); rst = 1'b1; start = 1'b1; n = 8'd16;
    @(posedge clk); #1;
    check("rst_start_busy", busy, 0);
    @(negedge clk); rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("rst_start_idle", busy, 0);

    // Exhaustive sweep at W=8, F=4.
    for (int v = 0; v < 256; v++) begin
      run_op(8'(v), lat);
      x = v * 256;
      r = isqrt(x);
      check("sweep8_latency", lat, 8);
      check("sweep8_root", root, r);
      check("sweep8_rem", rem, x - r * r);
      check("sweep8_bound", (root * root <= x) && (x < (root + 1) * (root + 1)), 1);
    end

    // Exhaustive sweep at W=6, F=0.
    for (int v = 0; v < 64; v++) begin
      @(negedge clk); n6 = 6'(v); start6 = 1'b1;
      @(posedge clk); #1; start6 = 1'b0;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
        @(posedge clk); #1;
        if (done6) begin lat = i; break; end
      end
      r = isqrt(v);
      check("sweep6_latency", lat, 3);
      check("sweep6_root", root6, r);
      check("sweep6_rem", rem6, v - r * r);
      check("sweep6_bound", (root6 * root6 <= v) && (v < (root6 + 1) * (root6 + 1)), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
